// File: rtl/wshb_arb_pkg.sv
// Shared constants, master indices and FSM state type for the SDRAM Wishbone arbiter.
package wshb_arb_pkg;

  localparam int N_MASTERS_DEF = 3;

  localparam int VGA_IDX    = 0;
  localparam int STREAM_IDX = 1;
  localparam int MIRE_IDX   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // Index width that stays legal for a single-master build.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wshb_arbiter_if.sv
// Bus bundle between the Wishbone masters, the arbiter and the SDRAM slave port.
interface wshb_arbiter_if
  import wshb_arb_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF
);

  logic [N_MASTERS-1:0]       m_cyc;
  logic [N_MASTERS-1:0]       m_stb;
  logic [N_MASTERS-1:0]       m_we;
  logic [N_MASTERS-1:0][31:0] m_adr;
  logic [N_MASTERS-1:0][3:0]  m_sel;
  logic [N_MASTERS-1:0][31:0] m_dat_ms;
  logic                       m_urgent;
  logic [N_MASTERS-1:0]       m_ack;
  logic [31:0]                m_dat_sm;

  logic                       s_cyc;
  logic                       s_stb;
  logic                       s_we;
  logic [31:0]                s_adr;
  logic [3:0]                 s_sel;
  logic [31:0]                s_dat_ms;
  logic                       s_ack;
  logic [31:0]                s_dat_sm;

  // Arbiter acting as the shared slave seen by all masters.
  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_ms, m_urgent,
    output m_ack, m_dat_sm
  );

  // Arbiter acting as the single master of the SDRAM port.
  modport master (
    output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_ms,
    input  s_ack, s_dat_sm
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner selection: urgent VGA override, otherwise round-robin after last_owner.
module rr_pick
  import wshb_arb_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int IDX_W     = idx_width(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     last_owner,
  input  logic                 urgent,
  output logic [N_MASTERS-1:0] win_oh,
  output logic [IDX_W-1:0]     win_idx
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (urgent && req[VGA_IDX]) begin
      win_oh[VGA_IDX] = 1'b1;
      win_idx         = IDX_W'(VGA_IDX);
    end else begin
      // Scan starts one past the previous owner, so the owner itself is checked last.
      for (int off = 1; off <= N_MASTERS; off++) begin
        idx = IDX_W'((int'(last_owner) + off) % N_MASTERS);
        if (!found && req[idx]) begin
          found       = 1'b1;
          win_oh[idx] = 1'b1;
          win_idx     = idx;
        end
      end
    end
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Shares the SDRAM Wishbone slave port among N_MASTERS masters with round-robin,
// an urgent override for VGA, and hold-limit preemption on ack boundaries.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int MAX_HOLD  = 64
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  wshb_arbiter_if.slave        mst,
  wshb_arbiter_if.master       slv,
  output logic [N_MASTERS-1:0] grant
);

  localparam int IDX_W  = idx_width(N_MASTERS);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     owner;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [N_MASTERS-1:0] win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic                 owner_cyc;
  logic                 bus_act;
  logic                 ack_hit;
  logic                 others_req;
  logic                 at_limit;

  rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req        (mst.m_cyc),
    .last_owner (owner),
    .urgent     (mst.m_urgent),
    .win_oh     (win_oh),
    .win_idx    (win_idx)
  );

  // owner doubles as last_owner: it holds the most recent winner in every state.
  assign owner_cyc  = mst.m_cyc[owner];
  assign bus_act    = (state == ST_OWN) && owner_cyc;
  assign ack_hit    = bus_act && slv.s_ack;
  assign others_req = |(mst.m_cyc & ~grant);
  assign at_limit   = (hold_cnt >= HOLD_LAST);

  assign slv.s_cyc    = bus_act;
  assign slv.s_stb    = bus_act && mst.m_stb[owner];
  assign slv.s_we     = bus_act && mst.m_we[owner];
  assign slv.s_adr    = mst.m_adr[owner];
  assign slv.s_sel    = mst.m_sel[owner];
  assign slv.s_dat_ms = mst.m_dat_ms[owner];
  assign mst.m_dat_sm = slv.s_dat_sm;

  always_comb begin
    mst.m_ack        = '0;
    mst.m_ack[owner] = ack_hit;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= IDX_W'(N_MASTERS - 1);
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|mst.m_cyc) begin
            state    <= ST_OWN;
            grant    <= win_oh;
            owner    <= win_idx;
            hold_cnt <= '0;
          end
        end
        ST_OWN: begin
          if (!owner_cyc) begin
            state <= ST_IDLE;
            grant <= '0;
          end else if (ack_hit) begin
            // Preempt only on an acked beat so no strobe is left hanging.
            if (at_limit && others_req) begin
              state <= ST_GAP;
              grant <= '0;
            end
            if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Scoreboard bench for wshb_arbiter: masters push expected read data per transfer,
// every routed ack pops and checks it; scenario tasks check grant timing inline.
module tb_wshb_arbiter;

  logic       sys_clk;
  logic       sys_rst;
  logic [2:0] grant;
  logic       force_ack;

  wshb_arbiter_if #(.N_MASTERS(3)) bus ();

  wshb_arbiter #(
    .N_MASTERS (3),
    .MAX_HOLD  (64)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .mst     (bus.slave),
    .slv     (bus.master),
    .grant   (grant)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Slave model: acks every strobe, read data is a fixed mix of the slave-side fields.
  assign bus.s_ack    = force_ack | (bus.s_cyc & bus.s_stb);
  assign bus.s_dat_sm = bus.s_adr ^ bus.s_dat_ms ^ {bus.s_sel, 3'b000, bus.s_we, 24'h0};

  int          vectors;
  int          miscompares;
  int          remaining [3];
  bit          presented [3];
  bit          ack_seen  [3];
  int          ack_cnt   [3];
  logic [31:0] m_adr_r   [3];
  logic [31:0] exp_q     [3][$];
  logic [2:0]  s_grant;
  logic [2:0]  s_mack;
  logic        s_scyc;

  function automatic logic [3:0] sel_of(int i);
    return 4'(1 << i);
  endfunction

  function automatic logic [31:0] dat_of(int i);
    return 32'(32'h1111_1111 * (i + 1));
  endfunction

  function automatic logic [31:0] exp_data(int i, logic [31:0] adr);
    logic we;
    we = (i == 1);
    return adr ^ dat_of(i) ^ {sel_of(i), 3'b000, we, 24'h0};
  endfunction

  task automatic drive_masters();
    for (int i = 0; i < 3; i++) begin
      if (ack_seen[i]) begin
        ack_seen[i]  = 1'b0;
        presented[i] = 1'b0;
        if (remaining[i] > 0) remaining[i]--;
        m_adr_r[i] = m_adr_r[i] + 32'd4;
      end
      if (remaining[i] > 0 && !presented[i]) begin
        exp_q[i].push_back(exp_data(i, m_adr_r[i]));
        presented[i] = 1'b1;
      end
      bus.m_cyc[i]    = (remaining[i] > 0);
      bus.m_stb[i]    = (remaining[i] > 0);
      bus.m_we[i]     = (i == 1);
      bus.m_adr[i]    = m_adr_r[i];
      bus.m_sel[i]    = sel_of(i);
      bus.m_dat_ms[i] = dat_of(i);
    end
  endtask

  // One clock: sample and score at negedge, then advance the masters after the edge.
  task automatic tick();
    logic [31:0] exp;
    @(negedge sys_clk);
    s_grant = grant;
    s_mack  = bus.m_ack;
    s_scyc  = bus.s_cyc;
    for (int i = 0; i < 3; i++) begin
      if (bus.m_ack[i]) begin
        ack_seen[i] = 1'b1;
        ack_cnt[i]++;
        vectors++;
        if (exp_q[i].size() == 0) begin
          miscompares++;
          $display("FAIL sb_ack m%0d: ack seen, required none outstanding", i);
        end else begin
          exp = exp_q[i].pop_front();
          if (bus.m_dat_sm !== exp) begin
            miscompares++;
            $display("FAIL sb_data m%0d: got %h required %h", i, bus.m_dat_sm, exp);
          end
        end
      end
    end
    @(posedge sys_clk);
    #1;
    drive_masters();
  endtask

  task automatic start(int m, int n);
    remaining[m] = n;
    drive_masters();
  endtask

  task automatic stop_all();
    for (int i = 0; i < 3; i++) begin
      remaining[i] = 0;
      presented[i] = 1'b0;
      ack_seen[i]  = 1'b0;
      exp_q[i].delete();
    end
    drive_masters();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    stop_all();
    tick();
    tick();
    sys_rst = 1'b0;
    bus.m_urgent = 1'b0;
    clear_counts();
  endtask

  task automatic run_until(int m, int target, int budget, string tag);
    int n;
    n = 0;
    while (ack_cnt[m] < target && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (ack_cnt[m] != target) begin
      miscompares++;
      $display("FAIL %s_timeout: m%0d acks %0d required %0d", tag, m, ack_cnt[m], target);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if (grant !== 3'b000 || bus.s_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: grant %b s_cyc %b required 000/0", grant, bus.s_cyc);
    end
    start(0, 4);
    force_ack = 1'b1;
    tick();
    tick();
    vectors++;
    if (s_grant !== 3'b000 || s_scyc !== 1'b0 || s_mack !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_hold: grant %b s_cyc %b m_ack %b required 000/0/000", s_grant, s_scyc, s_mack);
    end
    force_ack = 1'b0;
    stop_all();
    sys_rst = 1'b0;
    clear_counts();
    tick();
    vectors++;
    if (s_grant !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_release: grant %b required 000", s_grant);
    end
  endtask

  task automatic test_single_master();
    clear_counts();
    start(2, 10);
    tick();
    vectors++;
    if (s_grant !== 3'b000) begin
      miscompares++;
      $display("FAIL single_arb_cycle: grant %b required 000", s_grant);
    end
    tick();
    vectors++;
    if (s_grant !== 3'b100) begin
      miscompares++;
      $display("FAIL single_grant: grant %b required 100", s_grant);
    end
    run_until(2, 10, 40, "single");
    tick();
    tick();
    vectors++;
    if (ack_cnt[2] != 10 || ack_cnt[0] != 0 || ack_cnt[1] != 0) begin
      miscompares++;
      $display("FAIL single_counts: acks %0d/%0d/%0d required 0/0/10", ack_cnt[0], ack_cnt[1], ack_cnt[2]);
    end
    vectors++;
    if (s_grant !== 3'b000 || s_scyc !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: grant %b s_cyc %b required 000/0", s_grant, s_scyc);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    start(1, 200);
    start(2, 200);
    tick();
    tick();
    vectors++;
    if (s_grant !== 3'b010) begin
      miscompares++;
      $display("FAIL preempt_first: grant %b required 010", s_grant);
    end
    run_until(1, 64, 100, "preempt");
    vectors++;
    if (s_grant !== 3'b010) begin
      miscompares++;
      $display("FAIL preempt_last_beat: grant %b required 010", s_grant);
    end
    tick();
    vectors++;
    if (s_grant !== 3'b000 || s_scyc !== 1'b0 || s_mack !== 3'b000) begin
      miscompares++;
      $display("FAIL preempt_gap: grant %b s_cyc %b m_ack %b required 000/0/000", s_grant, s_scyc, s_mack);
    end
    tick();
    vectors++;
    if (s_grant !== 3'b000) begin
      miscompares++;
      $display("FAIL preempt_arb: grant %b required 000", s_grant);
    end
    tick();
    vectors++;
    if (s_grant !== 3'b100 || ack_cnt[1] != 64) begin
      miscompares++;
      $display("FAIL preempt_handover: grant %b m1 acks %0d required 100/64", s_grant, ack_cnt[1]);
    end
    stop_all();
    tick();
    tick();
  endtask

  task automatic test_urgent();
    do_reset();
    start(0, 1);
    run_until(0, 1, 10, "urgent_prep");
    tick();
    tick();
    bus.m_urgent = 1'b1;
    start(0, 5);
    start(1, 5);
    start(2, 5);
    tick();
    tick();
    vectors++;
    if (s_grant !== 3'b001) begin
      miscompares++;
      $display("FAIL urgent_win: grant %b required 001", s_grant);
    end
    stop_all();
    tick();
    tick();
    bus.m_urgent = 1'b0;
    start(0, 5);
    start(1, 5);
    start(2, 5);
    tick();
    tick();
    vectors++;
    if (s_grant !== 3'b010) begin
      miscompares++;
      $display("FAIL rr_after_0: grant %b required 010", s_grant);
    end
    stop_all();
    tick();
    tick();
  endtask

  task automatic test_no_preempt();
    int n;
    int gaps;
    do_reset();
    start(0, 70);
    tick();
    n    = 0;
    gaps = 0;
    while (ack_cnt[0] < 70 && n < 100) begin
      tick();
      n++;
      if (!s_scyc) gaps++;
    end
    vectors++;
    if (ack_cnt[0] != 70 || n != 70) begin
      miscompares++;
      $display("FAIL hold_alone: acks %0d in %0d cycles required 70 in 70", ack_cnt[0], n);
    end
    vectors++;
    if (gaps != 0) begin
      miscompares++;
      $display("FAIL hold_no_gap: idle bus cycles %0d required 0", gaps);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    start(1, 50);
    start(2, 50);
    tick();
    tick();
    run_until(1, 5, 20, "rstmid");
    #2;
    sys_rst = 1'b1;
    #1;
    vectors++;
    if (grant !== 3'b000 || bus.s_cyc !== 1'b0 || bus.m_ack !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset: grant %b s_cyc %b m_ack %b required 000/0/000", grant, bus.s_cyc, bus.m_ack);
    end
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    vectors++;
    if (s_grant !== 3'b000 || s_mack !== 3'b000) begin
      miscompares++;
      $display("FAIL rstmid_arb: grant %b m_ack %b required 000/000", s_grant, s_mack);
    end
    tick();
    vectors++;
    if (s_grant !== 3'b010) begin
      miscompares++;
      $display("FAIL rstmid_rr: grant %b required 010", s_grant);
    end
    stop_all();
    tick();
    tick();
  endtask

  task automatic test_drop_with_ack();
    do_reset();
    start(0, 3);
    start(1, 10);
    tick();
    tick();
    vectors++;
    if (s_grant !== 3'b001) begin
      miscompares++;
      $display("FAIL drop_first: grant %b required 001", s_grant);
    end
    run_until(0, 3, 20, "drop");
    vectors++;
    if (s_mack !== 3'b001) begin
      miscompares++;
      $display("FAIL drop_last_ack: m_ack %b required 001", s_mack);
    end
    force_ack = 1'b1;
    tick();
    vectors++;
    if (s_scyc !== 1'b0 || s_mack !== 3'b000) begin
      miscompares++;
      $display("FAIL drop_release: s_cyc %b m_ack %b required 0/000", s_scyc, s_mack);
    end
    force_ack = 1'b0;
    tick();
    vectors++;
    if (s_grant !== 3'b000) begin
      miscompares++;
      $display("FAIL drop_idle: grant %b required 000", s_grant);
    end
    tick();
    vectors++;
    if (s_grant !== 3'b010 || ack_cnt[0] != 3) begin
      miscompares++;
      $display("FAIL drop_handover: grant %b m0 acks %0d required 010/3", s_grant, ack_cnt[0]);
    end
    stop_all();
    tick();
    tick();
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    sys_rst      = 1'b1;
    force_ack    = 1'b0;
    bus.m_urgent = 1'b0;
    for (int i = 0; i < 3; i++) begin
      remaining[i] = 0;
      presented[i] = 1'b0;
      ack_seen[i]  = 1'b0;
      ack_cnt[i]   = 0;
      m_adr_r[i]   = 32'h0010_0000 * (i + 1);
    end
    drive_masters();
    test_reset();
    test_single_master();
    test_preempt();
    test_urgent();
    test_no_preempt();
    test_reset_mid();
    test_drop_with_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 3, number of Wishbone masters sharing the SDRAM slave port (0=vga, 1=stream, 2=mire).
REQ-002 Parameter MAX_HOLD, default 64, acknowledged transfers after which the current owner is preempted if another master requests.
REQ-003 sys_clk  input  1  system clock (100 MHz); sole clock of the block.
REQ-004 sys_rst  input  1  reset; asynchronous, active-high.
REQ-005 m_cyc  input  N_MASTERS  per-master cycle request.
REQ-006 m_stb  input  N_MASTERS  per-master strobe.
REQ-007 m_we  input  N_MASTERS  per-master write enable.
REQ-008 m_adr  input  N_MASTERS x 32  per-master byte address.
REQ-009 m_sel  input  N_MASTERS x 4  per-master byte select.
REQ-010 m_dat_ms  input  N_MASTERS x 32  per-master write data.
REQ-011 m_urgent  input  1  master 0 starvation flag (VGA FIFO low).
REQ-012 m_ack  output  N_MASTERS  per-master acknowledge.
REQ-013 m_dat_sm  output  32  read data, broadcast to all masters.
REQ-014 s_cyc, s_stb, s_we  output  1 each  slave-side control.
REQ-015 s_adr  output  32; s_sel  output  4; s_dat_ms  output  32; slave-side address/select/data.
REQ-016 s_ack  input  1; s_dat_sm  input  32; slave acknowledge and read data.
REQ-017 grant  output  N_MASTERS  one-hot current owner, registered.

Function
REQ-018 FSM states: IDLE, OWN, GAP.
REQ-019 IDLE: no grant; s_cyc=s_stb=0; if any m_cyc high, pick a winner and go OWN next cycle (1-cycle arbitration latency).
REQ-020 Winner: if m_urgent and m_cyc[0], master 0; else round-robin, first requesting index after last_owner, modulo N_MASTERS.
REQ-021 On entry to OWN: grant one-hot registered, last_owner updated, hold_cnt cleared.
REQ-022 OWN: s_cyc/s_stb/s_we/s_adr/s_sel/s_dat_ms combinationally driven from the granted master; m_ack[g]=s_ack; all other m_ack bits 0.
REQ-023 m_dat_sm = s_dat_sm at all times.
REQ-024 hold_cnt increments on each s_ack in OWN; saturates at MAX_HOLD.
REQ-025 OWN -> IDLE when m_cyc[g] falls (same-cycle s_cyc low, no ack routed).
REQ-026 OWN -> GAP on an s_ack with hold_cnt=MAX_HOLD-1 and any other m_cyc high; preemption only on an ack cycle, never with a strobe pending unacked.
REQ-027 GAP: grant=0, s_cyc=0 for exactly one cycle, then IDLE; preempted master keeps cyc and re-arbitrates normally.
REQ-028 No other master requesting at hold limit: owner keeps bus, hold_cnt stays saturated.
REQ-029 Simultaneous drop of m_cyc[g] and s_ack: ack delivered, then IDLE.
REQ-030 s_ack while s_cyc=0 ignored (no m_ack, no count).

Reset
REQ-031 sys_rst asserted at any time: state=IDLE, grant=0, hold_cnt=0, last_owner=N_MASTERS-1 (master 0 first), s_cyc=s_stb=0, m_ack=0, immediately (asynchronous).
REQ-032 Reset mid-transfer abandons the transfer; no ack issued for it after release.

Structure
REQ-033 Package wshb_arb_pkg holds N_MASTERS default, master index constants (VGA_IDX=0, STREAM_IDX=1, MIRE_IDX=2) and the state enum.
REQ-034 Sub-module rr_pick (combinational: request vector, last_owner, urgent -> one-hot winner) instantiated once.

Verification
REQ-035 Single master 2 requests, slave acks every cycle for 10 transfers -> grant=3'b100 one cycle after m_cyc, exactly 10 m_ack[2], others 0.
REQ-036 Masters 1,2 request continuously from reset, last_owner=2 -> grant to 1; after 64 acks, one GAP cycle with s_cyc=0, then grant 2.
REQ-037 All three request, m_urgent=1, last_owner=0 -> master 0 wins despite round-robin order.
REQ-038 Master 0 alone at hold_cnt=64 -> no preemption, no GAP, transfers continue.
REQ-039 sys_rst pulsed mid-burst of master 1 -> grant=0, s_cyc=0 asynchronously; after release, first grant follows round-robin from last_owner=2.
REQ-040 Owner drops m_cyc in the same cycle as s_ack -> ack delivered to it, next cycle IDLE, waiting master granted the cycle after.
